char_window_renderer: RTL

CHAR_WINDOW_RENDERER -- requirements
Module: char_window_renderer

---
 rtl/char_window_renderer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/char_window_renderer.sv
// Character window renderer: tracks an 8x16 glyph cell magnified by M over the raster,
// strobes the glyph ROM and colours each pixel with a fixed two-stage latency.
module char_window_renderer (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        displayActive,
    input  logic [9:0]  posHorStart,
    input  logic [9:0]  posVerStart,
    input  logic [2:0]  charSize,
    input  logic [7:0]  romData,
    input  logic [8:0]  fgColor,
    input  logic [8:0]  bgColor,
    output logic        readEn,
    output logic [3:0]  rowCnt,
    output logic [2:0]  colCnt,
    output logic [8:0]  vgaRGB
);

    localparam int unsigned CW = 10;
    localparam int unsigned MW = 3;
    localparam int unsigned RW = 4;
    localparam int unsigned XW = 3;
    localparam int unsigned PW = 9;

    typedef enum logic {V_IDLE, V_ACTIVE} v_state_t;
    typedef enum logic {H_IDLE, H_ACTIVE} h_state_t;

    v_state_t        v_state, v_state_nx;
    h_state_t        h_state, h_state_nx;
    logic [CW-1:0]   pos_h, pos_h_nx, pos_v, pos_v_nx;
    logic [MW-1:0]   mag, mag_nx;
    logic [RW-1:0]   row, row_nx;
    logic [MW-1:0]   v_sub, v_sub_nx, h_sub, h_sub_nx;
    logic [XW-1:0]   col, col_nx;
    logic            read_en_nx, da_s1, da_s1_nx;
    logic [RW-1:0]   row_cnt_nx;
    logic [XW-1:0]   col_cnt_nx;
    logic            re_d, re_d_nx, da_d, da_d_nx;
    logic [XW-1:0]   col_d, col_d_nx;
    logic [PW-1:0]   rgb_nx;

    logic            frame_start_c, line_start_c, h_enter_c, h_act_c;
    logic [MW-1:0]   mag_last_c, cur_sub_c;
    logic [XW-1:0]   cur_col_c;

    // Next-state, counters and pipeline inputs
    always_comb begin
        pos_h_nx    = pos_h;
        pos_v_nx    = pos_v;
        mag_nx      = mag;
        v_state_nx  = v_state;
        row_nx      = row;
        v_sub_nx    = v_sub;
        h_state_nx  = h_state;
        col_nx      = col;
        h_sub_nx    = h_sub;
        h_enter_c   = 1'b0;
        h_act_c     = 1'b0;
        cur_col_c   = col;
        cur_sub_c   = h_sub;
        rgb_nx      = '0;

        frame_start_c = (hCount == CW'(0)) && (vCount == CW'(0));
        line_start_c  = (hCount == CW'(0));

        // Frame-start values take effect for decisions on the same clock
        if (frame_start_c) begin
            pos_h_nx = posHorStart;
            pos_v_nx = posVerStart;
            if (charSize == MW'(0))      mag_nx = MW'(1);
            else if (charSize > MW'(4))  mag_nx = MW'(4);
            else                         mag_nx = charSize;
        end
        mag_last_c = mag_nx - MW'(1);

        if (line_start_c) begin
            case (v_state)
                V_IDLE: begin
                    if (vCount == pos_v_nx) begin
                        v_state_nx = V_ACTIVE;
                        row_nx     = '0;
                        v_sub_nx   = '0;
                    end
                end
                V_ACTIVE: begin
                    if (v_sub == mag_last_c) begin
                        v_sub_nx = '0;
                        if (row == RW'(15)) begin
                            v_state_nx = V_IDLE;
                            row_nx     = '0;
                        end else begin
                            row_nx = row + RW'(1);
                        end
                    end else begin
                        v_sub_nx = v_sub + MW'(1);
                    end
                end
                default: v_state_nx = V_IDLE;
            endcase
        end

        // The entry clock is itself glyph pixel (0,0)
        h_enter_c = (h_state == H_IDLE) && (v_state_nx == V_ACTIVE) && (hCount == pos_h_nx);
        h_act_c   = (h_state == H_ACTIVE) || h_enter_c;
        if (h_enter_c) begin
            cur_col_c = '0;
            cur_sub_c = '0;
        end

        if (h_act_c) begin
            h_state_nx = H_ACTIVE;
            col_nx     = cur_col_c;
            if (cur_sub_c == mag_last_c) begin
                h_sub_nx = '0;
                if (cur_col_c == XW'(7)) begin
                    h_state_nx = H_IDLE;
                    col_nx     = '0;
                end else begin
                    col_nx = cur_col_c + XW'(1);
                end
            end else begin
                h_sub_nx = cur_sub_c + MW'(1);
            end
        end

        read_en_nx = h_act_c;
        row_cnt_nx = row_nx;
        col_cnt_nx = h_act_c ? cur_col_c : XW'(0);
        da_s1_nx   = displayActive;

        re_d_nx    = readEn;
        col_d_nx   = colCnt;
        da_d_nx    = da_s1;

        if (da_d) begin
            if (re_d && romData[XW'(XW'(7) - col_d)]) rgb_nx = fgColor;
            else                                      rgb_nx = bgColor;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_h   <= '0;
            pos_v   <= '0;
            mag     <= MW'(1);
            v_state <= V_IDLE;
            row     <= '0;
            v_sub   <= '0;
            h_state <= H_IDLE;
            col     <= '0;
            h_sub   <= '0;
            readEn  <= 1'b0;
            rowCnt  <= '0;
            colCnt  <= '0;
            da_s1   <= 1'b0;
            re_d    <= 1'b0;
            col_d   <= '0;
            da_d    <= 1'b0;
            vgaRGB  <= '0;
        end else begin
            pos_h   <= pos_h_nx;
            pos_v   <= pos_v_nx;
            mag     <= mag_nx;
            v_state <= v_state_nx;
            row     <= row_nx;
            v_sub   <= v_sub_nx;
            h_state <= h_state_nx;
            col     <= col_nx;
            h_sub   <= h_sub_nx;
            readEn  <= read_en_nx;
            rowCnt  <= row_cnt_nx;
            colCnt  <= col_cnt_nx;
            da_s1   <= da_s1_nx;
            re_d    <= re_d_nx;
            col_d   <= col_d_nx;
            da_d    <= da_d_nx;
            vgaRGB  <= rgb_nx;
        end
    end

endmodule
